// File: rtl/vx_tex_client.sv
// Texture bus initiator: tags TEX requests with a pending-table slot and rebuilds writeback commits from responses.
// Optional perf counters are enabled by defining VX_TEX_CLIENT_PERF_EN.
module vx_tex_client #(
   parameter int NUM_LANES     = 4,
   parameter int NUM_PENDING   = 8,
   parameter int UUID_WIDTH    = 44,
   parameter int WID_WIDTH     = 2,
   parameter int META_WIDTH    = 40,
   parameter int LOD_BITS      = 4,
   parameter int STAGE_BITS    = 1,
   parameter int PERF_CTR_BITS = 44,
   localparam int SLOT_W       = $clog2(NUM_PENDING),
   localparam int TAG_W        = UUID_WIDTH + SLOT_W
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          exe_valid,
   output logic                          exe_ready,
   input  logic [UUID_WIDTH-1:0]         exe_uuid,
   input  logic [WID_WIDTH-1:0]          exe_wid,
   input  logic [NUM_LANES-1:0]          exe_mask,
   input  logic [STAGE_BITS-1:0]         exe_stage,
   input  logic [META_WIDTH-1:0]         exe_meta,
   input  logic [2*NUM_LANES*32-1:0]     exe_coords,
   input  logic [NUM_LANES*LOD_BITS-1:0] exe_lod,
   output logic                          tex_req_valid,
   input  logic                          tex_req_ready,
   output logic [NUM_LANES-1:0]          tex_req_mask,
   output logic [2*NUM_LANES*32-1:0]     tex_req_coords,
   output logic [NUM_LANES*LOD_BITS-1:0] tex_req_lod,
   output logic [STAGE_BITS-1:0]         tex_req_stage,
   output logic [TAG_W-1:0]              tex_req_tag,
   input  logic                          tex_rsp_valid,
   output logic                          tex_rsp_ready,
   input  logic [NUM_LANES*32-1:0]       tex_rsp_texels,
   input  logic [TAG_W-1:0]              tex_rsp_tag,
   output logic                          cmt_valid,
   input  logic                          cmt_ready,
   output logic [UUID_WIDTH-1:0]         cmt_uuid,
   output logic [WID_WIDTH-1:0]          cmt_wid,
   output logic [NUM_LANES-1:0]          cmt_mask,
   output logic [META_WIDTH-1:0]         cmt_meta,
   output logic [NUM_LANES*32-1:0]       cmt_data,
   output logic [SLOT_W:0]               pending_count
`ifdef VX_TEX_CLIENT_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0]      perf_stall_cycles,
   output logic [PERF_CTR_BITS-1:0]      perf_latency_sum
`endif
);

   logic [NUM_PENDING-1:0] tbl_valid;
   logic [UUID_WIDTH-1:0]  tbl_uuid [NUM_PENDING];
   logic [WID_WIDTH-1:0]   tbl_wid  [NUM_PENDING];
   logic [NUM_LANES-1:0]   tbl_mask [NUM_PENDING];
   logic [META_WIDTH-1:0]  tbl_meta [NUM_PENDING];

   logic                   full;
   logic [SLOT_W-1:0]      alloc_slot;
   logic                   exe_fire;
   logic                   rsp_fire;
   logic [SLOT_W-1:0]      rsp_slot;
   logic [UUID_WIDTH-1:0]  rsp_uuid;
   logic                   rsp_hit;
   logic                   free_en;

   // Lowest free slot wins; searched on the pre-cycle valid vector so a slot freed this cycle is not reused yet.
   always_comb begin
      alloc_slot = '0;
      for (int i = NUM_PENDING - 1; i >= 0; i--) begin
         if (!tbl_valid[i]) alloc_slot = SLOT_W'(i);
      end
   end

   assign full          = &tbl_valid;
   assign exe_ready     = ~full & (~tex_req_valid | tex_req_ready);
   assign exe_fire      = exe_valid & exe_ready;
   assign tex_rsp_ready = ~cmt_valid | cmt_ready;
   assign rsp_fire      = tex_rsp_valid & tex_rsp_ready;
   assign rsp_slot      = tex_rsp_tag[SLOT_W-1:0];
   assign rsp_uuid      = tex_rsp_tag[TAG_W-1:SLOT_W];
   assign rsp_hit       = tbl_valid[rsp_slot];
   assign free_en       = rsp_fire & rsp_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tbl_valid     <= '0;
         pending_count <= '0;
      end else begin
         if (free_en)  tbl_valid[rsp_slot]   <= 1'b0;
         if (exe_fire) tbl_valid[alloc_slot] <= 1'b1;
         case ({exe_fire, free_en})
            2'b10:   pending_count <= pending_count + 1'b1;
            2'b01:   pending_count <= pending_count - 1'b1;
            default: pending_count <= pending_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PENDING; i++) begin
            tbl_uuid[i] <= '0;
            tbl_wid[i]  <= '0;
            tbl_mask[i] <= '0;
            tbl_meta[i] <= '0;
         end
      end else if (exe_fire) begin
         tbl_uuid[alloc_slot] <= exe_uuid;
         tbl_wid[alloc_slot]  <= exe_wid;
         tbl_mask[alloc_slot] <= exe_mask;
         tbl_meta[alloc_slot] <= exe_meta;
      end
   end

   // Request register: payload only reloads on a new issue, so it holds while the texture unit stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tex_req_valid  <= 1'b0;
         tex_req_mask   <= '0;
         tex_req_coords <= '0;
         tex_req_lod    <= '0;
         tex_req_stage  <= '0;
         tex_req_tag    <= '0;
      end else if (exe_fire) begin
         tex_req_valid  <= 1'b1;
         tex_req_mask   <= exe_mask;
         tex_req_coords <= exe_coords;
         tex_req_lod    <= exe_lod;
         tex_req_stage  <= exe_stage;
         tex_req_tag    <= {exe_uuid, alloc_slot};
      end else if (tex_req_ready) begin
         tex_req_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmt_valid <= 1'b0;
         cmt_uuid  <= '0;
         cmt_wid   <= '0;
         cmt_mask  <= '0;
         cmt_meta  <= '0;
         cmt_data  <= '0;
      end else if (free_en) begin
         cmt_valid <= 1'b1;
         cmt_uuid  <= tbl_uuid[rsp_slot];
         cmt_wid   <= tbl_wid[rsp_slot];
         cmt_mask  <= tbl_mask[rsp_slot];
         cmt_meta  <= tbl_meta[rsp_slot];
         cmt_data  <= tex_rsp_texels;
      end else if (cmt_ready) begin
         cmt_valid <= 1'b0;
      end
   end

`ifdef VX_TEX_CLIENT_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cycles <= '0;
         perf_latency_sum  <= '0;
      end else begin
         if (exe_valid && !exe_ready) perf_stall_cycles <= perf_stall_cycles + 1'b1;
         perf_latency_sum <= perf_latency_sum + PERF_CTR_BITS'(pending_count);
      end
   end
`else
   // Perf counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
   // A response to an idle slot is legal after a mid-flight reset, so it only warns.
   always_ff @(posedge clk) begin
      if (reset_n && rsp_fire) begin
         assert (rsp_hit)
            else $warning("vx_tex_client: response to idle slot %0d dropped", rsp_slot);
         if (rsp_hit) begin
            assert (tbl_uuid[rsp_slot] == rsp_uuid)
               else $error("vx_tex_client: uuid %0h does not match slot %0d", rsp_uuid, rsp_slot);
         end
      end
   end
`endif

endmodule

// File: tb/tb_vx_tex_client.sv
// Directed self-checking bench for vx_tex_client: single request, fill, out-of-order, backpressure and reset.
module tb_vx_tex_client;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         exe_valid, exe_ready;
   logic [43:0]  exe_uuid;
   logic [1:0]   exe_wid;
   logic [3:0]   exe_mask;
   logic [0:0]   exe_stage;
   logic [39:0]  exe_meta;
   logic [255:0] exe_coords;
   logic [15:0]  exe_lod;
   logic         tex_req_valid, tex_req_ready;
   logic [3:0]   tex_req_mask;
   logic [255:0] tex_req_coords;
   logic [15:0]  tex_req_lod;
   logic [0:0]   tex_req_stage;
   logic [46:0]  tex_req_tag;
   logic         tex_rsp_valid, tex_rsp_ready;
   logic [127:0] tex_rsp_texels;
   logic [46:0]  tex_rsp_tag;
   logic         cmt_valid, cmt_ready;
   logic [43:0]  cmt_uuid;
   logic [1:0]   cmt_wid;
   logic [3:0]   cmt_mask;
   logic [39:0]  cmt_meta;
   logic [127:0] cmt_data;
   logic [3:0]   pending_count;

   int n_checks = 0;
   int n_fail   = 0;
   int slot_uuid [8];

   vx_tex_client dut (
      .clk(clk), .reset_n(reset_n),
      .exe_valid(exe_valid), .exe_ready(exe_ready),
      .exe_uuid(exe_uuid), .exe_wid(exe_wid), .exe_mask(exe_mask), .exe_stage(exe_stage),
      .exe_meta(exe_meta), .exe_coords(exe_coords), .exe_lod(exe_lod),
      .tex_req_valid(tex_req_valid), .tex_req_ready(tex_req_ready),
      .tex_req_mask(tex_req_mask), .tex_req_coords(tex_req_coords), .tex_req_lod(tex_req_lod),
      .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
      .tex_rsp_valid(tex_rsp_valid), .tex_rsp_ready(tex_rsp_ready),
      .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
      .cmt_valid(cmt_valid), .cmt_ready(cmt_ready),
      .cmt_uuid(cmt_uuid), .cmt_wid(cmt_wid), .cmt_mask(cmt_mask), .cmt_meta(cmt_meta),
      .cmt_data(cmt_data), .pending_count(pending_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [46:0] mk_tag(input int u, input int s);
      return {44'(u), 3'(s)};
   endfunction

   function automatic logic [127:0] texv(input int s);
      logic [31:0] w;
      w = 32'hC0DE0000 | 32'(s);
      return {w, w, w, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int u, input int w, input int m, input int meta);
      exe_uuid = 44'(u);
      exe_wid  = 2'(w);
      exe_mask = 4'(m);
      exe_meta = 40'(meta);
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      assert (obs === exp)
         else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         end
   endtask

   initial begin
      reset_n        = 1'b0;
      exe_valid      = 1'b0;
      exe_uuid       = '0;
      exe_wid        = '0;
      exe_mask       = '0;
      exe_stage      = '0;
      exe_meta       = '0;
      exe_coords     = '0;
      exe_lod        = '0;
      tex_req_ready  = 1'b1;
      tex_rsp_valid  = 1'b0;
      tex_rsp_texels = '0;
      tex_rsp_tag    = '0;
      cmt_ready      = 1'b1;

      // reset state
      repeat (2) tick();
      checkOutput("rst_req_valid", 256'(tex_req_valid), 256'd0);
      checkOutput("rst_cmt_valid", 256'(cmt_valid), 256'd0);
      checkOutput("rst_pending", 256'(pending_count), 256'd0);
      checkOutput("rst_exe_ready", 256'(exe_ready), 256'd1);
      checkOutput("rst_rsp_ready", 256'(tex_rsp_ready), 256'd1);
      checkOutput("rst_req_tag", 256'(tex_req_tag), 256'd0);
      checkOutput("rst_cmt_data", 256'(cmt_data), 256'd0);
      reset_n = 1'b1;

      // single request
      applyStimulus(5, 1, 4'b1011, 'h12);
      exe_stage  = 1'b1;
      exe_coords = {8{32'h3F80_0001}};
      exe_lod    = 16'h4321;
      exe_valid  = 1'b1;
      tick();
      exe_valid = 1'b0;
      checkOutput("t1_req_valid", 256'(tex_req_valid), 256'd1);
      checkOutput("t1_req_tag", 256'(tex_req_tag), 256'(mk_tag(5, 0)));
      checkOutput("t1_req_mask", 256'(tex_req_mask), 256'hB);
      checkOutput("t1_req_coords", tex_req_coords, {8{32'h3F80_0001}});
      checkOutput("t1_req_lod", 256'(tex_req_lod), 256'h4321);
      checkOutput("t1_req_stage", 256'(tex_req_stage), 256'd1);
      checkOutput("t1_pending", 256'(pending_count), 256'd1);
      tex_rsp_tag    = mk_tag(5, 0);
      tex_rsp_texels = {4{32'hAABBCCDD}};
      tex_rsp_valid  = 1'b1;
      tick();
      tex_rsp_valid = 1'b0;
      checkOutput("t1_req_valid_drop", 256'(tex_req_valid), 256'd0);
      checkOutput("t1_cmt_valid", 256'(cmt_valid), 256'd1);
      checkOutput("t1_cmt_uuid", 256'(cmt_uuid), 256'd5);
      checkOutput("t1_cmt_wid", 256'(cmt_wid), 256'd1);
      checkOutput("t1_cmt_mask", 256'(cmt_mask), 256'hB);
      checkOutput("t1_cmt_meta", 256'(cmt_meta), 256'h12);
      checkOutput("t1_cmt_data", 256'(cmt_data), 256'({4{32'hAABBCCDD}}));
      checkOutput("t1_pending", 256'(pending_count), 256'd0);
      tick();
      checkOutput("t1_cmt_consumed", 256'(cmt_valid), 256'd0);

      // fill all slots back to back
      exe_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16 + i, 2, 4'hF, 'h100 + i);
         slot_uuid[i] = 16 + i;
         tick();
         checkOutput($sformatf("fill_tag%0d", i), 256'(tex_req_tag), 256'(mk_tag(16 + i, i)));
      end
      exe_valid = 1'b0;
      checkOutput("fill_pending", 256'(pending_count), 256'd8);
      checkOutput("fill_exe_ready", 256'(exe_ready), 256'd0);
      tex_rsp_tag   = mk_tag(19, 3);
      tex_rsp_valid = 1'b1;
      tick();
      tex_rsp_valid = 1'b0;
      checkOutput("free3_exe_ready", 256'(exe_ready), 256'd1);
      checkOutput("free3_pending", 256'(pending_count), 256'd7);
      checkOutput("free3_cmt_uuid", 256'(cmt_uuid), 256'd19);
      applyStimulus(40, 0, 4'h1, 'h200);
      slot_uuid[3] = 40;
      exe_valid = 1'b1;
      tick();
      exe_valid = 1'b0;
      checkOutput("realloc3_tag", 256'(tex_req_tag), 256'(mk_tag(40, 3)));
      checkOutput("realloc3_pending", 256'(pending_count), 256'd8);

      // simultaneous alloc of slot 0 and free of slot 4
      tex_rsp_tag   = mk_tag(16, 0);
      tex_rsp_valid = 1'b1;
      tick();
      checkOutput("free0_pending", 256'(pending_count), 256'd7);
      tex_rsp_tag = mk_tag(20, 4);
      applyStimulus(50, 3, 4'h2, 'h300);
      slot_uuid[0] = 50;
      exe_valid = 1'b1;
      tick();
      tex_rsp_valid = 1'b0;
      applyStimulus(51, 3, 4'h3, 'h301);
      slot_uuid[4] = 51;
      checkOutput("simul_pending", 256'(pending_count), 256'd7);
      checkOutput("simul_tag", 256'(tex_req_tag), 256'(mk_tag(50, 0)));
      checkOutput("simul_cmt_uuid", 256'(cmt_uuid), 256'd20);
      tick();
      exe_valid = 1'b0;
      checkOutput("after_simul_tag", 256'(tex_req_tag), 256'(mk_tag(51, 4)));
      checkOutput("after_simul_pending", 256'(pending_count), 256'd8);

      // drain every slot
      tex_rsp_valid = 1'b1;
      for (int s = 0; s < 8; s++) begin
         tex_rsp_tag = mk_tag(slot_uuid[s], s);
         tick();
         checkOutput($sformatf("drain_uuid%0d", s), 256'(cmt_uuid), 256'(slot_uuid[s]));
      end
      tex_rsp_valid = 1'b0;
      checkOutput("drain_pending", 256'(pending_count), 256'd0);
      tick();

      // out-of-order returns; slot 0 uses an all-zero mask
      exe_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(60 + k, k, (k == 0) ? 0 : 4'h5 + k, 'h600 + k);
         tick();
      end
      exe_valid = 1'b0;
      checkOutput("ooo_tag2", 256'(tex_req_tag), 256'(mk_tag(62, 2)));
      tex_rsp_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         int s;
         s = (k == 0) ? 2 : k - 1;
         tex_rsp_tag    = mk_tag(60 + s, s);
         tex_rsp_texels = texv(s);
         tick();
         checkOutput($sformatf("ooo_uuid%0d", s), 256'(cmt_uuid), 256'(60 + s));
         checkOutput($sformatf("ooo_meta%0d", s), 256'(cmt_meta), 256'('h600 + s));
         checkOutput($sformatf("ooo_data%0d", s), 256'(cmt_data), 256'(texv(s)));
         checkOutput($sformatf("ooo_mask%0d", s), 256'(cmt_mask), 256'((s == 0) ? 0 : 4'h5 + s));
      end
      tex_rsp_valid = 1'b0;

      // commit backpressure
      cmt_ready = 1'b0;
      #1;
      checkOutput("bp_rsp_ready", 256'(tex_rsp_ready), 256'd0);
      for (int c = 0; c < 5; c++) begin
         tick();
         checkOutput($sformatf("bp_cmt_valid%0d", c), 256'(cmt_valid), 256'd1);
         checkOutput($sformatf("bp_cmt_uuid%0d", c), 256'(cmt_uuid), 256'd61);
         checkOutput($sformatf("bp_cmt_data%0d", c), 256'(cmt_data), 256'(texv(1)));
      end
      cmt_ready = 1'b1;
      tick();
      checkOutput("bp_cmt_release", 256'(cmt_valid), 256'd0);

      // request backpressure
      tex_req_ready = 1'b0;
      applyStimulus(70, 1, 4'h7, 'h700);
      exe_valid = 1'b1;
      tick();
      applyStimulus(71, 1, 4'h8, 'h701);
      checkOutput("rbp_exe_ready", 256'(exe_ready), 256'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput($sformatf("rbp_valid%0d", c), 256'(tex_req_valid), 256'd1);
         checkOutput($sformatf("rbp_tag%0d", c), 256'(tex_req_tag), 256'(mk_tag(70, 0)));
      end
      checkOutput("rbp_pending", 256'(pending_count), 256'd1);
      tex_req_ready = 1'b1;
      tick();
      exe_valid = 1'b0;
      checkOutput("rbp_next_tag", 256'(tex_req_tag), 256'(mk_tag(71, 1)));
      checkOutput("rbp_next_pending", 256'(pending_count), 256'd2);
      applyStimulus(72, 2, 4'h9, 'h702);
      exe_valid = 1'b1;
      tick();
      exe_valid = 1'b0;
      checkOutput("mid_pending3", 256'(pending_count), 256'd3);

      // reset with three requests in flight
      reset_n = 1'b0;
      #1;
      checkOutput("midrst_req_valid", 256'(tex_req_valid), 256'd0);
      checkOutput("midrst_cmt_valid", 256'(cmt_valid), 256'd0);
      checkOutput("midrst_pending", 256'(pending_count), 256'd0);
      checkOutput("midrst_req_tag", 256'(tex_req_tag), 256'd0);
      checkOutput("midrst_exe_ready", 256'(exe_ready), 256'd1);
      tick();
      reset_n = 1'b1;
      tex_rsp_tag   = mk_tag(71, 1);
      tex_rsp_valid = 1'b1;
      tick();
      tex_rsp_valid = 1'b0;
      checkOutput("late_rsp_cmt_valid", 256'(cmt_valid), 256'd0);
      checkOutput("late_rsp_pending", 256'(pending_count), 256'd0);
      tick();
      checkOutput("late_rsp_cmt_valid2", 256'(cmt_valid), 256'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
